// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the camera capture front end.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        ARM   = 2'd2,
        FRAME = 2'd3
    } state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_W        = 16;

endpackage

// File: rtl/cam_byte_pack.sv
// Pairs camera bytes into 16-bit pixels; the first byte of each pair lands in the upper half.
module cam_byte_pack
    import cam_capture_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             byte_en,
    input  logic [7:0]       byte_in,
    output logic             pixel_valid,
    output logic [PIX_W-1:0] pixel_data,
    output logic             partial
);

    logic       toggle_r;
    logic [7:0] hi_r;

    // Byte toggle and high-byte holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_r <= 1'b0;
            hi_r     <= 8'h00;
        end else if (clr) begin
            toggle_r <= 1'b0;
        end else if (byte_en) begin
            toggle_r <= ~toggle_r;
            if (!toggle_r) begin
                hi_r <= byte_in;
            end
        end
    end

    assign pixel_valid = byte_en & toggle_r;
    assign pixel_data  = {hi_r, byte_in};
    // A set toggle when the line ends means a high byte is still waiting for its partner.
    assign partial     = toggle_r;

endmodule

// File: rtl/cam_frame_capture.sv
// Camera capture front end: registers the parallel bus, packs byte pairs and drives
// the SDRAM write-FIFO port with per-frame geometry and error tracking.
module cam_frame_capture
    import cam_capture_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CW       = 11
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic             CAM_VSYNC,
    input  logic             CAM_HREF,
    input  logic [7:0]       CAM_D,
    input  logic             FIFO_FULL,
    output logic [PIX_W-1:0] WR_DATA,
    output logic             WR,
    output logic             WR_LOAD,
    output logic             FRAME_DONE,
    output logic [15:0]      FRAME_CNT,
    output logic [CW-1:0]    X_CNT,
    output logic [CW-1:0]    Y_CNT,
    output logic             OVERFLOW,
    output logic             LINE_ERR
);

    logic             vsync_r, href_r, vsync_d_r, href_d_r;
    logic [7:0]       d_r;
    logic             line_act_r, over_len_r;
    state_t           state_r, state_s;
    logic             vfall_s, vrise_s, hrise_s, hfall_s;
    logic             in_frame_s, cap_s, end_line_s, pack_clr_s;
    logic             x_full_s, y_full_s;
    logic             pixel_valid_s, partial_s;
    logic [PIX_W-1:0] pixel_data_s;

    // Input stage S1 plus one-cycle history for edge detection
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vsync_r   <= 1'b0;
            href_r    <= 1'b0;
            d_r       <= 8'h00;
            vsync_d_r <= 1'b0;
            href_d_r  <= 1'b0;
        end else begin
            vsync_r   <= CAM_VSYNC;
            href_r    <= CAM_HREF;
            d_r       <= CAM_D;
            vsync_d_r <= vsync_r;
            href_d_r  <= href_r;
        end
    end

    assign vfall_s    = vsync_d_r & ~vsync_r;
    assign vrise_s    = vsync_r & ~vsync_d_r;
    assign hrise_s    = href_r & ~href_d_r;
    assign hfall_s    = href_d_r & ~href_r;
    assign in_frame_s = (state_r == FRAME);
    // A line already running when FRAME is entered never sets line_act_r, so it is skipped.
    assign cap_s      = in_frame_s & href_r & (line_act_r | hrise_s);
    assign end_line_s = in_frame_s & line_act_r & hfall_s;
    assign pack_clr_s = ~in_frame_s | hfall_s;
    assign x_full_s   = (X_CNT == CW'(H_ACTIVE));
    assign y_full_s   = (Y_CNT == CW'(V_ACTIVE));

    cam_byte_pack u_pack (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .clr         (pack_clr_s),
        .byte_en     (cap_s),
        .byte_in     (d_r),
        .pixel_valid (pixel_valid_s),
        .pixel_data  (pixel_data_s),
        .partial     (partial_s)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; an ENABLE drop inside a frame waits for the frame to end
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (ENABLE) state_s = SYNC; else state_s = IDLE;
            SYNC:    if (!ENABLE) state_s = IDLE; else if (vfall_s) state_s = ARM; else state_s = SYNC;
            ARM:     state_s = FRAME;
            FRAME:   if (vrise_s) state_s = ENABLE ? SYNC : IDLE; else state_s = FRAME;
            default: state_s = IDLE;
        endcase
    end

    // Write port, geometry counters and sticky status
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WR_DATA    <= {PIX_W{1'b0}};
            WR         <= 1'b0;
            WR_LOAD    <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_CNT  <= 16'd0;
            X_CNT      <= {CW{1'b0}};
            Y_CNT      <= {CW{1'b0}};
            OVERFLOW   <= 1'b0;
            LINE_ERR   <= 1'b0;
            line_act_r <= 1'b0;
            over_len_r <= 1'b0;
        end else begin
            WR         <= 1'b0;
            WR_LOAD    <= (state_s == ARM);
            FRAME_DONE <= 1'b0;
            line_act_r <= cap_s;
            if (state_s == ARM) begin
                X_CNT      <= {CW{1'b0}};
                Y_CNT      <= {CW{1'b0}};
                OVERFLOW   <= 1'b0;
                LINE_ERR   <= 1'b0;
                over_len_r <= 1'b0;
            end else begin
                if (pixel_valid_s) begin
                    WR_DATA <= pixel_data_s;
                    if (x_full_s) begin
                        over_len_r <= 1'b1;
                    end else begin
                        // X advances even when the FIFO drops the pixel, keeping geometry intact.
                        X_CNT <= X_CNT + CW'(1);
                        if (!y_full_s) begin
                            if (FIFO_FULL) OVERFLOW <= 1'b1;
                            else           WR       <= 1'b1;
                        end
                    end
                end
                if (end_line_s) begin
                    if (partial_s || !x_full_s || over_len_r) LINE_ERR <= 1'b1;
                    if (!y_full_s) Y_CNT <= Y_CNT + CW'(1);
                    X_CNT      <= {CW{1'b0}};
                    over_len_r <= 1'b0;
                end
                if (in_frame_s && vrise_s) begin
                    if (!y_full_s) LINE_ERR <= 1'b1;
                    FRAME_DONE <= 1'b1;
                    FRAME_CNT  <= FRAME_CNT + 16'd1;
                end
            end
        end
    end

endmodule
